// File: rtl/twiddle_gen.sv
// twiddle_gen: forward FFT twiddle-factor generator for a 64-point frame
// (radix-4 ordering k = n[3:0] * {0,2,1,3}[n[5:4]]). Two-stage pipeline:
// stage 1 registers the twiddle index k, stage 2 registers the quarter-wave
// table lookup with sign handling.
// Optional feature: define TWIDDLE_INV_EN to emit the conjugate twiddle
// (tw_im = +sin) for inverse FFT use.
// Handshake: do_en is a pure valid strobe (no ready); each di_en=1 cycle
// yields exactly one do_en=1 cycle two clocks later, tw_re/tw_im hold otherwise.
module twiddle_gen #(
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    di_en,
    input  logic                    sync,
    output logic signed [WIDTH-1:0] tw_re,
    output logic signed [WIDTH-1:0] tw_im,
    output logic                    do_en,
    output logic                    do_first
);

    // Quarter-wave entry S[i] = round(sin(pi*i/32) * (2^(WIDTH-1)-1)),
    // derived from sin values in parts-per-billion so it folds at elaboration.
    function automatic logic signed [WIDTH-1:0] sin_entry(input int i);
        logic [63:0] ppb;
        logic [63:0] full_scale;
        logic [63:0] q;
        case (i)
            0:       ppb = 64'd0;
            1:       ppb = 64'd98017140;
            2:       ppb = 64'd195090322;
            3:       ppb = 64'd290284677;
            4:       ppb = 64'd382683432;
            5:       ppb = 64'd471396737;
            6:       ppb = 64'd555570233;
            7:       ppb = 64'd634393284;
            8:       ppb = 64'd707106781;
            9:       ppb = 64'd773010453;
            10:      ppb = 64'd831469612;
            11:      ppb = 64'd881921264;
            12:      ppb = 64'd923879533;
            13:      ppb = 64'd956940336;
            14:      ppb = 64'd980785280;
            15:      ppb = 64'd995184727;
            16:      ppb = 64'd1000000000;
            default: ppb = 64'd0;
        endcase
        full_scale = (64'd1 << (WIDTH - 1)) - 64'd1;
        q = (ppb * full_scale + 64'd500000000) / 64'd1000000000;
        return $signed(WIDTH'(q));
    endfunction

    logic signed [WIDTH-1:0] sin_tab [0:16];

    for (genvar g = 0; g < 17; g++) begin : g_tab
        assign sin_tab[g] = sin_entry(g);
    end

    // Sample counter and stage-1 state
    logic [5:0] n_q, n_d;
    logic [5:0] k1_q, k1_d;
    logic       v1_q, v1_d;
    logic       first1_q, first1_d;

    // Stage-2 (output) state
    logic signed [WIDTH-1:0] tw_re_q, tw_re_d;
    logic signed [WIDTH-1:0] tw_im_q, tw_im_d;
    logic                    do_en_q, do_en_d;
    logic                    do_first_q, do_first_d;

    logic [5:0] n_eff;
    logic [1:0] m_sel;
    logic [5:0] k_c;

    // Counter advance, sync realignment and twiddle index computation
    always_comb begin
        n_eff    = sync ? 6'd0 : n_q;
        m_sel    = 2'd0;
        case (n_eff[5:4])
            2'd0:    m_sel = 2'd0;
            2'd1:    m_sel = 2'd2;
            2'd2:    m_sel = 2'd1;
            default: m_sel = 2'd3;
        endcase
        k_c      = {2'b00, n_eff[3:0]} * {4'b0000, m_sel};
        n_d      = n_q;
        k1_d     = k1_q;
        v1_d     = di_en;
        first1_d = di_en & ((n_q == 6'd0) | sync);
        if (di_en) begin
            n_d  = n_eff + 6'd1;
            k1_d = k_c;
        end
    end

    // Counter and stage-1 registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n_q      <= 6'd0;
            k1_q     <= 6'd0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
        end else begin
            n_q      <= n_d;
            k1_q     <= k1_d;
            v1_q     <= v1_d;
            first1_q <= first1_d;
        end
    end

    logic [4:0]              idx_lo;
    logic [4:0]              idx_hi;
    logic signed [WIDTH-1:0] cos_v;
    logic signed [WIDTH-1:0] sin_v;

    // Quarter-wave decode: k[5:4] is the quadrant select, k[3:0] the offset
    always_comb begin
        idx_lo = {1'b0, k1_q[3:0]};
        idx_hi = 5'd16 - idx_lo;
        cos_v  = '0;
        sin_v  = '0;
        case (k1_q[5:4])
            2'd0: begin
                cos_v = sin_tab[idx_hi];
                sin_v = sin_tab[idx_lo];
            end
            2'd1: begin
                cos_v = -sin_tab[idx_lo];
                sin_v = sin_tab[idx_hi];
            end
            2'd2: begin
                cos_v = -sin_tab[idx_hi];
                sin_v = -sin_tab[idx_lo];
            end
            default: begin
                cos_v = '0;
                sin_v = '0;
            end
        endcase
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        do_en_d    = v1_q;
        do_first_d = first1_q;
        if (v1_q) begin
            tw_re_d = cos_v;
`ifdef TWIDDLE_INV_EN
            tw_im_d = sin_v;
`else
            tw_im_d = -sin_v;
`endif
        end
    end

    // Stage-2 output registers; twiddle holds while no new sample arrives
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tw_re_q    <= '0;
            tw_im_q    <= '0;
            do_en_q    <= 1'b0;
            do_first_q <= 1'b0;
        end else begin
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
            do_en_q    <= do_en_d;
            do_first_q <= do_first_d;
        end
    end

    assign tw_re    = tw_re_q;
    assign tw_im    = tw_im_q;
    assign do_en    = do_en_q;
    assign do_first = do_first_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: self-checking bench for twiddle_gen (WIDTH=16).
// Reference model computes twiddles directly from cos/sin of 2*pi*k/64.
// Build with +define+TWIDDLE_INV_EN to check the conjugate variant.
module tb_twiddle_gen;

    localparam int    W  = 16;
    localparam real   FS = 32767.0;
    localparam real   PI = 3.14159265358979323846;
`ifdef TWIDDLE_INV_EN
    localparam int    IM_SIGN = -1;
`else
    localparam int    IM_SIGN = 1;
`endif

    logic                clock;
    logic                reset_n;
    logic                di_en;
    logic                sync;
    logic signed [W-1:0] tw_re;
    logic signed [W-1:0] tw_im;
    logic                do_en;
    logic                do_first;

    twiddle_gen #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .di_en    (di_en),
        .sync     (sync),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .do_en    (do_en),
        .do_first (do_first)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    int          m_n = 0;
    logic [31:0] last_tw = '0;
    logic [33:0] exp_q[$];

    logic [W-1:0] got_re [64];
    logic [W-1:0] got_im [64];
    logic         got_first [64];

    typedef struct {
        int n;
        int re;
        int im;
        bit first;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else return -$rtoi(-r + 0.5);
    endfunction

    // Twiddle for frame sample n, straight from the trig definition
    function automatic logic [31:0] tw_of(input int n);
        int  m;
        int  k;
        int  re;
        int  im;
        real a;
        case (n / 16)
            0:       m = 0;
            1:       m = 2;
            2:       m = 1;
            default: m = 3;
        endcase
        k  = (n % 16) * m;
        a  = 2.0 * PI * k / 64.0;
        re = rnd($cos(a) * FS);
        im = rnd(-$sin(a) * FS) * IM_SIGN;
        return {re[15:0], im[15:0]};
    endfunction

    // Reference model: expected {do_en, do_first, tw_re, tw_im} for one input cycle
    task automatic model_push(input logic en, input logic sy);
        int nu;
        logic [31:0] t;
        if (en) begin
            nu = sy ? 0 : m_n;
            t = tw_of(nu);
            exp_q.push_back({1'b1, (nu == 0), t});
            last_tw = t;
            m_n = (nu + 1) % 64;
        end else begin
            exp_q.push_back({2'b00, last_tw});
        end
    endtask

    task automatic sb_check();
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty step%0d got=%h exp=entry", step_no, {do_en, do_first, tw_re, tw_im});
        end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_step%0d", step_no), {do_en, do_first, tw_re, tw_im}, e);
        end
    endtask

    // One clock cycle: drive inputs, advance, compare the output now visible
    task automatic step(input logic en, input logic sy);
        di_en = en;
        sync  = sy;
        model_push(en, sy);
        @(posedge clock);
        #1;
        step_no++;
        sb_check();
    endtask

    task automatic apply_reset();
        di_en   = 1'b0;
        sync    = 1'b0;
        reset_n = 1'b0;
        #2;
        check("reset_out", {do_en, do_first, tw_re, tw_im}, 34'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_n     = 0;
        last_tw = '0;
        exp_q.delete();
        exp_q.push_back(34'd0);
    endtask

    initial begin
        vecs[0] = '{0,  32767,  0,      1'b1};
        vecs[1] = '{5,  32767,  0,      1'b0};
        vecs[2] = '{15, 32767,  0,      1'b0};
        vecs[3] = '{16, 32767,  0,      1'b0};
        vecs[4] = '{20, 23170,  -23170, 1'b0};
        vecs[5] = '{24, 0,      -32767, 1'b0};
        vecs[6] = '{40, 23170,  -23170, 1'b0};
        vecs[7] = '{49, 31356,  -9512,  1'b0};
        vecs[8] = '{63, -9512,  31356,  1'b0};

        reset_n = 1'b1;
        di_en   = 1'b0;
        sync    = 1'b0;
        #1;
        apply_reset();

        // Back-to-back full frame, capture each twiddle by sample index
        for (int i = 0; i < 66; i++) begin
            step(i < 64, 1'b0);
            if (i >= 1 && i <= 64) begin
                got_re[i-1]    = tw_re;
                got_im[i-1]    = tw_im;
                got_first[i-1] = do_first;
            end
        end
        for (int i = 0; i < 9; i++) begin
            check($sformatf("vec_n%0d", vecs[i].n),
                  {1'b0, got_first[vecs[i].n], got_re[vecs[i].n], got_im[vecs[i].n]},
                  {1'b0, vecs[i].first, 16'(vecs[i].re), 16'(vecs[i].im * IM_SIGN)});
        end

        // Gapped strobes: 1 on / 3 off over two frames
        apply_reset();
        for (int s = 0; s < 128; s++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            check($sformatf("gap_s%0d", s), {do_en, do_first, tw_re, tw_im},
                  {1'b1, ((s % 64) == 0), tw_of(s % 64)});
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end

        // Sync mid-frame at n=37, with idle-cycle syncs that must be ignored
        apply_reset();
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("sync_first", {do_en, do_first, tw_re, tw_im}, {1'b1, 1'b1, 16'sd32767, 16'sd0});
        step(1'b1, 1'b0);
        check("sync_next", {do_en, do_first, tw_re, tw_im}, {1'b1, 1'b0, 16'sd32767, 16'sd0});
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset one cycle after a strobe at n=30 drops that twiddle
        apply_reset();
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("post_reset_first", {32'd0, do_en, do_first}, 34'd3);

        // Randomized strobe/sync traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
